// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Used for statistics counters that must never roll back to small values.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Far-end checker for an incrementing test pattern: acquires lock on a run of
// +1 words, then counts and records every break in the sequence while locked.
module counter_checker #(
  parameter int N          = 16,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [N-1:0]     din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [N-1:0]     last_exp,
  output logic [N-1:0]     last_rcv
);

  // Input handshake: din is consumed on every rising edge where din_valid is
  // high; there is no ready/back-pressure, and idle cycles are always legal.

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t        state;
  logic          have_prev;
  logic [MW-1:0] match_run;
  logic [LW-1:0] miss_run;
  logic [N-1:0]  exp_word;

  logic          match;
  logic [MW-1:0] match_next;
  logic [LW-1:0] miss_next;
  logic          err_inc;

  assign match      = (din == exp_word);
  assign match_next = (have_prev && match) ? match_run + 1'b1 : '0;
  assign miss_next  = miss_run + 1'b1;
  assign err_inc    = din_valid && !clear && (state == LOCKED) && !match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      have_prev <= 1'b0;
      match_run <= '0;
      miss_run  <= '0;
      exp_word  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      last_exp  <= '0;
      last_rcv  <= '0;
    end else if (clear) begin
      state     <= SEARCH;
      have_prev <= 1'b0;
      match_run <= '0;
      miss_run  <= '0;
      exp_word  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      last_exp  <= '0;
      last_rcv  <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (din_valid) begin
        case (state)
          SEARCH: begin
            exp_word  <= din + 1'b1;
            have_prev <= 1'b1;
            match_run <= match_next;
            if (have_prev && match && (match_next == MW'(LOCK_COUNT))) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              miss_run <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              exp_word <= exp_word + 1'b1;
              miss_run <= '0;
            end else begin
              // Resynchronise to the received word so a single slip costs one error.
              err_pulse <= 1'b1;
              last_exp  <= exp_word;
              last_rcv  <= din;
              exp_word  <= din + 1'b1;
              miss_run  <= miss_next;
              if (miss_next == LW'(LOSS_COUNT)) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                match_run <= '0;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_count (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (err_inc),
    .clr  (clear),
    .q    (err_count)
  );

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
Receive-side companion to the free-running N-bit counter. The counter serves as a test-pattern source on a data path such as a FIFO, DDR or host pipe. This block sits at the far end of that path and checks that each valid word equals the previous word plus one, modulo 2^N.
- Reports lock status, a saturating error count, a per-error pulse, and the expected/received values of the most recent error.
- Used for link and buffer bring-up on the camera data path.

Parameters:
N, 16, data/counter width in bits
LOCK_COUNT, 4, consecutive correct increments needed to declare lock (>=1)
LOSS_COUNT, 2, consecutive mismatches while locked that drop lock (>=1)
ERR_W, 32, error counter width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
din_valid  input  1  din carries a word this cycle
din  input  N  received counter word
clear  input  1  synchronous clear of state and statistics
locked  output  1  sequence lock achieved
err_pulse  output  1  one-cycle pulse per mismatch while locked
err_count  output  ERR_W  saturating count of mismatches while locked
last_exp  output  N  expected value at most recent error
last_rcv  output  N  received value at most recent error

Behaviour:
- Reset (rst_n low, asynchronous): every output is 0. Internal state goes to SEARCH with have_prev=0, match_run=0, miss_run=0, exp=0.
- Cycles with din_valid=0 change nothing. Gaps are legal in every state.
- "match" means din == exp. exp is always the previous accepted word + 1, mod 2^N, so 2^N-1 -> 0 is a match.
- State SEARCH, on each valid word:
  - if have_prev=1 and match: match_run += 1; otherwise match_run = 0.
  - then exp <= din+1 and have_prev <= 1.
  - When a match makes match_run reach LOCK_COUNT: go to LOCKED, locked <= 1, miss_run <= 0.
  - Mismatches in SEARCH are never counted as errors.
- State LOCKED, on each valid word:
  - match: exp <= exp+1, miss_run <= 0.
  - mismatch: err_pulse <= 1 for exactly one cycle; err_count += 1, saturating at 2^ERR_W-1; last_exp <= exp; last_rcv <= din; exp <= din+1 (resynchronise to the received value); miss_run += 1.
  - If miss_run reaches LOSS_COUNT: go to SEARCH, locked <= 0, match_run <= 0, have_prev stays 1. err_count, last_exp and last_rcv are kept.
- Latency: every output is registered and updates on the clock edge that samples the valid word. err_pulse and locked are therefore visible in the cycle after din_valid.
- clear=1: same effect as reset, but synchronous, and it has priority over a simultaneous din_valid (that word is discarded).
- Reset asserted mid-operation: immediate return to the reset state, no partial updates.

Decomposition:
- No shared package is needed. State encoding (SEARCH/LOCKED) is a localparam inside the module.
- One natural sub-module, sat_counter (parameter W; inputs inc, clr; output q). It implements the saturating err_count and is reusable for other statistics counters.
- match_run and miss_run are sized $clog2(LOCK_COUNT+1) and $clog2(LOSS_COUNT+1) respectively.

Test Plan:
1. Defaults; after reset feed 0,1,...,9 back-to-back. Expect locked to rise the cycle after word 4 is sampled; err_count=0; err_pulse never high.
2. Feed 0xFFFC..0x0003 with random din_valid gaps. Expect locked after 0x0000, no error across the wrap, and gaps with no effect.
3. Locked; feed 10,12,13,14. Expect one err_pulse the cycle after 12; err_count=1; last_exp=11; last_rcv=12; 13 and 14 match, so no further errors and locked stays 1.
4. Locked; feed 5,100,7. Expect errors on 5 and 100; locked=0 the cycle after 100; err_count=2; last_exp=6 (5+1), last_rcv=100; the 7 is a SEARCH mismatch, not counted.
5. ERR_W=3; after lock, alternate mismatch/match for 10 mismatches. Expect err_count to stick at 7 while err_pulse still fires on all 10.
6. Locked with err_count=3. Pulse clear with din_valid=1 and din=exp: all outputs 0 and the word is ignored. Then drop rst_n mid-stream: outputs 0 immediately, without waiting for a clock edge.
